// File: rtl/vip_sobel_param.sv
// -----------------------------------------------------------------------------
// vip_sobel_param
// Sobel edge engine for one camera stream (RGB565 in, RGB565 out).
// Keeps two line buffers of luma and a 3x3 window. Produces a bypass, grey,
// binary-edge or edge-overlay stream with a fixed 6-cycle latency.
//
// Ports
//   clk, rst_n                  pixel clock, asynchronous active-low reset
//   mode[1:0], threshold[10:0]  runtime controls, latched at vsync rise
//   pre_frame_vsync/href/de     input frame, line and pixel-valid syncs
//   pre_rgb[15:0]               input RGB565 pixel
//   post_frame_vsync/href/de    input syncs delayed by 6 cycles
//   post_rgb[15:0]              processed pixel, 0 when post_frame_de is low
//   edge_cnt[CNT_W-1:0]         edge-pixel count of the previous frame
//   edge_cnt_vld                one-cycle pulse when edge_cnt is updated
// -----------------------------------------------------------------------------
module vip_sobel_param #(
  parameter int          H_MAX      = 1024,
  parameter int          CNT_W      = 20,
  parameter logic [15:0] EDGE_COLOR = 16'hF800
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic [10:0]      threshold,
  input  logic             pre_frame_vsync,
  input  logic             pre_frame_href,
  input  logic             pre_frame_de,
  input  logic [15:0]      pre_rgb,
  output logic             post_frame_vsync,
  output logic             post_frame_href,
  output logic             post_frame_de,
  output logic [15:0]      post_rgb,
  output logic [CNT_W-1:0] edge_cnt,
  output logic             edge_cnt_vld
);

  localparam int AW  = (H_MAX > 1) ? $clog2(H_MAX) : 1;
  localparam int XW  = $clog2(H_MAX) + 2;  // room to count past H_MAX on overlong lines
  localparam int YW  = 12;
  localparam int LAT = 6;

  // Weighted luma sum before the >>8; fits 16 bits (max 256*255).
  function automatic logic [15:0] luma_acc(input logic [15:0] px);
    return 16'd77  * {8'h00, px[15:11], px[15:13]}
         + 16'd150 * {8'h00, px[10:5],  px[10:9]}
         + 16'd29  * {8'h00, px[4:0],   px[4:2]};
  endfunction

  // One column/row of a Sobel kernel: a + 2b + c, max 1020.
  function automatic logic [10:0] tap_sum(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c);
    return {3'b000, a} + {2'b00, b, 1'b0} + {3'b000, c};
  endfunction

  // |p - n| without going through a signed intermediate.
  function automatic logic [10:0] abs_diff(input logic [10:0] p, input logic [10:0] n);
    return (p >= n) ? (p - n) : (n - p);
  endfunction

  // ---------------------------------------------------------------- position
  logic          vsync_d_r, href_d_r;
  logic [1:0]    mode_r;
  logic [10:0]   thr_r;
  logic [XW-1:0] x_r;
  logic [YW-1:0] y_r;
  logic          vsync_rise_s, href_fall_s;

  assign vsync_rise_s = pre_frame_vsync & ~vsync_d_r;
  assign href_fall_s  = ~pre_frame_href & href_d_r;

  // Sync edge detect, frame-latched controls and pixel position counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d_r <= 1'b0;
      href_d_r  <= 1'b0;
      mode_r    <= 2'd0;
      thr_r     <= 11'd0;
      x_r       <= {XW{1'b0}};
      y_r       <= {YW{1'b0}};
    end else begin
      vsync_d_r <= pre_frame_vsync;
      href_d_r  <= pre_frame_href;
      if (vsync_rise_s) begin
        mode_r <= mode;
        thr_r  <= threshold;
      end
      if (href_fall_s)
        x_r <= {XW{1'b0}};
      else if (pre_frame_de && (x_r != {XW{1'b1}}))
        x_r <= x_r + XW'(1);
      if (vsync_rise_s)
        y_r <= {YW{1'b0}};
      else if (href_fall_s && (y_r != {YW{1'b1}}))
        y_r <= y_r + YW'(1);
    end
  end

  // ---------------------------------------------------------- delay lines
  logic [2:0]    sync_r [1:LAT];  // {vsync, href, de}
  logic [15:0]   rgb_r  [1:5];
  logic [7:0]    grey_r [2:5];
  logic [15:0]   lum1_r;
  logic [XW-1:0] x1_r, x2_r;
  logic [YW-1:0] y1_r, y2_r;

  // Sync/pixel delay lines and the two-stage grey conversion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i <= LAT; i++) sync_r[i] <= 3'b000;
      for (int i = 1; i <= 5; i++)   rgb_r[i]  <= 16'h0000;
      for (int i = 2; i <= 5; i++)   grey_r[i] <= 8'h00;
      lum1_r <= 16'h0000;
      x1_r   <= {XW{1'b0}};
      x2_r   <= {XW{1'b0}};
      y1_r   <= {YW{1'b0}};
      y2_r   <= {YW{1'b0}};
    end else begin
      sync_r[1] <= {pre_frame_vsync, pre_frame_href, pre_frame_de};
      for (int i = 2; i <= LAT; i++) sync_r[i] <= sync_r[i-1];
      rgb_r[1] <= pre_rgb;
      for (int i = 2; i <= 5; i++) rgb_r[i] <= rgb_r[i-1];
      lum1_r    <= luma_acc(pre_rgb);
      grey_r[2] <= 8'(lum1_r >> 8);
      for (int i = 3; i <= 5; i++) grey_r[i] <= grey_r[i-1];
      x1_r <= x_r;
      y1_r <= y_r;
      x2_r <= x1_r;
      y2_r <= y1_r;
    end
  end

  // ------------------------------------------------------- line buffers
  logic [7:0]    ram0 [0:H_MAX-1];  // row y-1
  logic [7:0]    ram1 [0:H_MAX-1];  // row y-2
  logic          in_range_s;
  logic [AW-1:0] addr_s;
  logic [7:0]    rd0_s, rd1_s;

  // Overlong pixels never touch the RAMs, so the address cannot wrap.
  assign in_range_s = (x2_r < XW'(H_MAX));
  assign addr_s     = in_range_s ? x2_r[AW-1:0] : {AW{1'b0}};
  assign rd0_s      = ram0[addr_s];
  assign rd1_s      = ram1[addr_s];

  // Line-buffer write: new luma into row0, old row0 shifts into row1.
  always_ff @(posedge clk) begin
    if (sync_r[2][0] && in_range_s) begin
      ram0[addr_s] <= grey_r[2];
      ram1[addr_s] <= rd0_s;
    end
  end

  // -------------------------------------------------------------- window
  logic [7:0] win_r [0:2][0:2];  // [row: 0=top][col: 2=newest]
  logic       border3_r;

  // 3x3 window shift on each valid pixel; centre is (x-1, y-1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) win_r[r][c] <= 8'h00;
      border3_r <= 1'b0;
    end else begin
      if (sync_r[2][0]) begin
        for (int r = 0; r < 3; r++) begin
          win_r[r][0] <= win_r[r][1];
          win_r[r][1] <= win_r[r][2];
        end
        win_r[0][2] <= rd1_s;
        win_r[1][2] <= rd0_s;
        win_r[2][2] <= grey_r[2];
      end
      border3_r <= (x2_r >= XW'(2)) & (y2_r >= YW'(2)) & in_range_s;
    end
  end

  // ------------------------------------------------- gradient / magnitude
  logic [10:0] gx_pos_s, gx_neg_s, gy_pos_s, gy_neg_s, mag_s;
  logic [10:0] ax4_r, ay4_r;
  logic        border4_r, edge5_r;

  assign gx_pos_s = tap_sum(win_r[0][2], win_r[1][2], win_r[2][2]);
  assign gx_neg_s = tap_sum(win_r[0][0], win_r[1][0], win_r[2][0]);
  assign gy_pos_s = tap_sum(win_r[2][0], win_r[2][1], win_r[2][2]);
  assign gy_neg_s = tap_sum(win_r[0][0], win_r[0][1], win_r[0][2]);
  assign mag_s    = ax4_r + ay4_r;  // max 2040, no overflow

  // Registered |Gx|, |Gy|, then thresholded edge decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ax4_r     <= 11'd0;
      ay4_r     <= 11'd0;
      border4_r <= 1'b0;
      edge5_r   <= 1'b0;
    end else begin
      ax4_r     <= abs_diff(gx_pos_s, gx_neg_s);
      ay4_r     <= abs_diff(gy_pos_s, gy_neg_s);
      border4_r <= border3_r;
      edge5_r   <= (mag_s >= thr_r) & border4_r;
    end
  end

  // -------------------------------------------------------------- output
  logic [15:0] out_s;
  logic        edge6_r;

  // Output pixel selection by the frame-latched mode.
  always_comb begin
    out_s = 16'h0000;
    if (sync_r[5][0]) begin
      case (mode_r)
        2'd0:    out_s = rgb_r[5];
        2'd1:    out_s = {grey_r[5][7:3], grey_r[5][7:2], grey_r[5][7:3]};
        2'd2:    out_s = edge5_r ? 16'hFFFF : 16'h0000;
        2'd3:    out_s = edge5_r ? EDGE_COLOR : rgb_r[5];
        default: out_s = rgb_r[5];
      endcase
    end else begin
      out_s = 16'h0000;
    end
  end

  assign post_frame_vsync = sync_r[LAT][2];
  assign post_frame_href  = sync_r[LAT][1];
  assign post_frame_de    = sync_r[LAT][0];

  // Output pixel register, with the edge flag kept alongside for counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      post_rgb <= 16'h0000;
      edge6_r  <= 1'b0;
    end else begin
      post_rgb <= out_s;
      edge6_r  <= edge5_r & sync_r[5][0];
    end
  end

  // --------------------------------------------------------- edge counter
  logic [CNT_W-1:0] cnt_r;
  logic             post_vs_d_r, post_vs_rise_s, inc_s;

  assign post_vs_rise_s = post_frame_vsync & ~post_vs_d_r;
  assign inc_s          = post_frame_de & edge6_r & mode_r[1];

  // Per-frame saturating edge count; an increment on the vsync-rise cycle
  // is the first pixel of the new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r        <= {CNT_W{1'b0}};
      post_vs_d_r  <= 1'b0;
      edge_cnt     <= {CNT_W{1'b0}};
      edge_cnt_vld <= 1'b0;
    end else begin
      post_vs_d_r <= post_frame_vsync;
      if (post_vs_rise_s) begin
        edge_cnt     <= cnt_r;
        edge_cnt_vld <= 1'b1;
        cnt_r        <= inc_s ? CNT_W'(1) : {CNT_W{1'b0}};
      end else begin
        edge_cnt_vld <= 1'b0;
        if (inc_s && (cnt_r != {CNT_W{1'b1}}))
          cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

endmodule
